// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc : multi-cycle signed ALU with a start/busy/done handshake.
//
// The operation is captured on the START edge. Single-cycle ops finish on the
// next edge. MUL adds one partial product per cycle (WIDTH cycles). SRA shifts
// one bit per cycle (max(1,s) cycles). R and the flags are held until the next
// operation completes.
//
// Optional build macro:
//   ALU_SAT_EN - ADD, SUB and MUL clamp to the signed range on overflow.
//                O is still set and C is unchanged. When this macro is
//                undefined, results wrap.
//
// Ports:
//   CLK   in   rising-edge clock
//   RST   in   asynchronous active-low reset
//   START in   request, sampled only while BUSY=0
//   A, B  in   signed operands; B[SHW-1:0] is the SRA shift amount
//   CTRL  in   opcode: ADD SUB AND OR XOR SLT MUL SRA (000..111)
//   BUSY  out  operation in progress
//   DONE  out  one-cycle pulse after R/flags update
//   R     out  signed result
//   O N Z C out overflow, negative, zero, carry/borrow/shift-out
// -----------------------------------------------------------------------------
module alu_mc #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   input  logic signed [WIDTH-1:0] A,
   input  logic signed [WIDTH-1:0] B,
   input  logic        [2:0]       CTRL,
   output logic                    BUSY,
   output logic                    DONE,
   output logic signed [WIDTH-1:0] R,
   output logic                    O,
   output logic                    N,
   output logic                    Z,
   output logic                    C
);

   // The counter must hold both WIDTH-1 (MUL) and any shift amount.
   localparam int CW = (SHW > $clog2(WIDTH + 1)) ? SHW : $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t                    state_q, state_d;
   logic                      done_q, done_d;
   logic signed [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d;
   logic        [2:0]         op_q, op_d;
   logic        [CW-1:0]      cnt_q, cnt_d;
   logic signed [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
   logic                      o_q, o_d, n_q, n_d, z_q, z_d, c_q, c_d;

   logic        [WIDTH:0]     sum_u;
   logic signed [WIDTH-1:0]   res;
   logic signed [2*WIDTH-1:0] pp, prod;
   logic                      res_o, res_c, fin;

`ifdef ALU_SAT_EN
   logic res_neg;

   function automatic logic signed [WIDTH-1:0] sat_val(input logic neg);
      return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      r_d     = r_q;
      o_d     = o_q;
      n_d     = n_q;
      z_d     = z_q;
      c_d     = c_q;
      sum_u   = '0;
      res     = '0;
      pp      = '0;
      prod    = '0;
      res_o   = 1'b0;
      res_c   = 1'b0;
      fin     = 1'b0;

      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = EXEC;
               a_d     = A;
               b_d     = B;
               op_d    = CTRL;
               acc_d   = '0;
               mcand_d = {{WIDTH{A[WIDTH-1]}}, A};
               cnt_d   = (CTRL == OP_SRA) ? CW'(B[SHW-1:0]) : CW'(WIDTH - 1);
            end
         end
         EXEC: begin
            case (op_q)
               OP_ADD: begin
                  sum_u = {1'b0, a_q} + {1'b0, b_q};
                  res   = sum_u[WIDTH-1:0];
                  res_c = sum_u[WIDTH];
                  res_o = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
                  fin   = 1'b1;
               end
               OP_SUB: begin
                  res   = a_q - b_q;
                  res_c = $unsigned(a_q) < $unsigned(b_q);
                  res_o = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
                  fin   = 1'b1;
               end
               OP_AND: begin res = a_q & b_q; fin = 1'b1; end
               OP_OR:  begin res = a_q | b_q; fin = 1'b1; end
               OP_XOR: begin res = a_q ^ b_q; fin = 1'b1; end
               OP_SLT: begin
                  res[0] = (a_q < b_q);
                  fin    = 1'b1;
               end
               OP_MUL: begin
                  // Shift-add over the multiplier bits. The final bit is the
                  // two's-complement sign bit, so its partial product is subtracted.
                  pp      = b_q[0] ? mcand_q : '0;
                  prod    = (cnt_q == '0) ? (acc_q - pp) : (acc_q + pp);
                  acc_d   = prod;
                  mcand_d = mcand_q <<< 1;
                  b_d     = b_q >>> 1;
                  cnt_d   = cnt_q - 1'b1;
                  res     = prod[WIDTH-1:0];
                  res_o   = (prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]});
                  fin     = (cnt_q == '0);
               end
               default: begin // OP_SRA
                  if (cnt_q == '0) begin
                     res = a_q;
                     fin = 1'b1;
                  end else begin
                     a_d   = a_q >>> 1;
                     cnt_d = cnt_q - 1'b1;
                     res   = a_q >>> 1;
                     res_c = a_q[0];
                     fin   = (cnt_q == CW'(1));
                  end
               end
            endcase

`ifdef ALU_SAT_EN
            // On overflow the true sign is the sign of A for ADD/SUB and the
            // sign of the full product for MUL.
            res_neg = (op_q == OP_MUL) ? prod[2*WIDTH-1] : a_q[WIDTH-1];
            if (res_o) res = sat_val(res_neg);
`endif

            if (fin) begin
               state_d = IDLE;
               done_d  = 1'b1;
               r_d     = res;
               o_d     = res_o;
               n_d     = res[WIDTH-1];
               z_d     = (res == '0);
               c_d     = res_c;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         r_q     <= '0;
         o_q     <= 1'b0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         r_q     <= r_d;
         o_q     <= o_d;
         n_q     <= n_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   assign BUSY = (state_q == EXEC);
   assign DONE = done_q;
   assign R    = r_q;
   assign O    = o_q;
   assign N    = n_q;
   assign Z    = z_q;
   assign C    = c_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc : scoreboard bench for alu_mc at WIDTH=4.
// Stimulus pushes the expected result, flags and DONE cycle into a queue.
// A monitor on the falling edge pops and compares whenever DONE is high.
// -----------------------------------------------------------------------------
module tb_alu_mc;

   localparam int W = 4;
`ifdef ALU_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011;
   localparam logic [2:0] XOR_ = 3'b100, SLT = 3'b101, MUL = 3'b110, SRA = 3'b111;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          START = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic [2:0]    CTRL = '0;
   logic          BUSY, DONE, O, N, Z, C;
   logic [W-1:0]  R;

   alu_mc #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CTRL(CTRL),
      .BUSY(BUSY), .DONE(DONE), .R(R), .O(O), .N(N), .Z(Z), .C(C)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      string        name;
      logic [W-1:0] r;
      logic         o;
      logic         c;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk_b(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_v(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: compare every DONE pulse against the oldest expectation.
   logic prev_done = 1'b0;
   always @(negedge CLK) begin
      if (DONE) begin
         exp_t e;
         chk_b("done_single_cycle", prev_done, 1'b0);
         if (sb.size() == 0) begin
            chk_i("spurious_done_queue_depth", sb.size(), 1);
         end else begin
            e = sb.pop_front();
            chk_v({e.name, "_R"}, R, e.r);
            chk_b({e.name, "_O"}, O, e.o);
            chk_b({e.name, "_N"}, N, e.r[W-1]);
            chk_b({e.name, "_Z"}, Z, (e.r == '0));
            chk_b({e.name, "_C"}, C, e.c);
            chk_b({e.name, "_busy_in_done"}, BUSY, 1'b0);
            chk_i({e.name, "_done_cycle"}, cyc, e.cyc);
         end
      end
      prev_done <= DONE;
   end

   task automatic drain(input string nm);
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge CLK);
      @(negedge CLK);
      chk_i({nm, "_completed"}, sb.size(), 0);
      sb.delete();
   endtask

   // Issue one operation. Its t0 edge is the next rising edge (cycle cyc+1).
   // DONE is expected lat cycles later.
   task automatic issue(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] r, input logic o,
                        input logic c, input int lat);
      @(negedge CLK);
      START = 1'b1; CTRL = op; A = a; B = b;
      sb.push_back('{nm, r, o, c, cyc + 1 + lat});
      @(negedge CLK);
      START = 1'b0;
      drain(nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, bound expired");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge CLK);
      chk_b("rst_BUSY", BUSY, 1'b0);
      chk_b("rst_DONE", DONE, 1'b0);
      chk_v("rst_R", R, 4'b0000);
      chk_b("rst_O", O, 1'b0);
      chk_b("rst_N", N, 1'b0);
      chk_b("rst_Z", Z, 1'b0);
      chk_b("rst_C", C, 1'b0);
      RST = 1'b1;
      @(negedge CLK);

      // Directed vectors: name, op, A, B, R, O, C, latency
      issue("add_ovf",   ADD,  4'b0111, 4'b0001, SAT ? 4'b0111 : 4'b1000, 1'b1, 1'b0, 1);
      issue("add_carry", ADD,  4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b1, 1);
      issue("sub_zero",  SUB,  4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b0, 1);
      issue("sub_borrow",SUB,  4'b0001, 4'b0010, 4'b1111, 1'b0, 1'b1, 1);
      issue("sub_ovf",   SUB,  4'b1000, 4'b0001, SAT ? 4'b1000 : 4'b0111, 1'b1, 1'b0, 1);
      issue("and",       AND_, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1);
      issue("or",        OR_,  4'b1100, 4'b0011, 4'b1111, 1'b0, 1'b0, 1);
      issue("xor",       XOR_, 4'b1111, 4'b0101, 4'b1010, 1'b0, 1'b0, 1);
      issue("slt_true",  SLT,  4'b1110, 4'b0001, 4'b0001, 1'b0, 1'b0, 1);
      issue("slt_false", SLT,  4'b0001, 4'b1110, 4'b0000, 1'b0, 1'b0, 1);
      issue("mul_neg",   MUL,  4'b0011, 4'b1110, 4'b1010, 1'b0, 1'b0, 4);
      issue("mul_ovf",   MUL,  4'b0100, 4'b0100, SAT ? 4'b0111 : 4'b0000, 1'b1, 1'b0, 4);
      issue("mul_minx",  MUL,  4'b1000, 4'b1111, SAT ? 4'b0111 : 4'b1000, 1'b1, 1'b0, 4);
      issue("sra_2",     SRA,  4'b1000, 4'b0010, 4'b1110, 1'b0, 1'b0, 2);
      issue("sra_1",     SRA,  4'b0111, 4'b0001, 4'b0011, 1'b0, 1'b1, 1);
      issue("sra_0",     SRA,  4'b0101, 4'b0000, 4'b0101, 1'b0, 1'b0, 1);
      issue("sra_3",     SRA,  4'b0110, 4'b0011, 4'b0000, 1'b0, 1'b1, 3);

      // START while busy is ignored and the operands are not re-sampled
      @(negedge CLK);
      START = 1'b1; CTRL = MUL; A = 4'b0011; B = 4'b1110;
      sb.push_back('{"busy_ignore", 4'b1010, 1'b0, 1'b0, cyc + 1 + 4});
      @(negedge CLK);
      chk_b("busy_ignore_BUSY", BUSY, 1'b1);
      CTRL = ADD; A = 4'b0001; B = 4'b0001;
      @(negedge CLK);
      START = 1'b0;
      drain("busy_ignore");

      // Back-to-back: START held through the DONE cycle
      @(negedge CLK);
      START = 1'b1; CTRL = ADD; A = 4'b0010; B = 4'b0011;
      sb.push_back('{"b2b_first", 4'b0101, 1'b0, 1'b0, cyc + 1 + 1});
      @(negedge CLK);
      chk_b("b2b_busy_t0", BUSY, 1'b1);
      @(negedge CLK);
      chk_b("b2b_busy_gap", BUSY, 1'b0);
      A = 4'b0110; B = 4'b0001;
      sb.push_back('{"b2b_second", 4'b0111, 1'b0, 1'b0, cyc + 1 + 1});
      @(negedge CLK);
      START = 1'b0;
      chk_b("b2b_busy_second", BUSY, 1'b1);
      drain("b2b");

      // Asynchronous reset in the middle of a MUL
      @(negedge CLK);
      START = 1'b1; CTRL = MUL; A = 4'b0011; B = 4'b0011;
      @(posedge CLK);
      #1 START = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      chk_b("midrst_BUSY", BUSY, 1'b0);
      chk_b("midrst_DONE", DONE, 1'b0);
      chk_v("midrst_R", R, 4'b0000);
      chk_b("midrst_O", O, 1'b0);
      chk_b("midrst_N", N, 1'b0);
      chk_b("midrst_Z", Z, 1'b0);
      chk_b("midrst_C", C, 1'b0);
      @(negedge CLK);
      RST = 1'b1;
      repeat (8) @(negedge CLK);
      chk_b("post_rst_idle", BUSY, 1'b0);
      issue("post_rst_add", ADD, 4'b1100, 4'b0010, 4'b1110, 1'b0, 1'b0, 1);

      chk_i("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, multi-cycle signed ALU with a start/busy/done handshake. It is the next-generation successor to the team's fixed-width single-cycle ALU:
- width is generic
- opcode grows to 3 bits
- adds iterative multiply and arithmetic shift
- adds a carry flag
- results are held until the next operation completes
It sits between the sequencer and the register file in the datapath.

Parameters:
WIDTH, 8, operand/result width in bits (≥4)
SHW, $clog2(WIDTH), shift-amount field width taken from B[SHW-1:0]

Ports:
CLK    input   1      rising-edge clock
RST    input   1      reset; asynchronous, active-low
START  input   1      request; sampled only when BUSY=0
A      input   WIDTH  signed operand A
B      input   WIDTH  signed operand B (shift amount for SRA)
CTRL   input   3      opcode
BUSY   output  1      operation in progress
DONE   output  1      one-cycle pulse: R/flags just updated
R      output  WIDTH  signed result, held until next completion
O      output  1      signed overflow
N      output  1      negative (R[WIDTH-1])
Z      output  1      zero (R==0)
C      output  1      carry/borrow/shift-out

Behaviour:
- Reset (RST=0, asynchronous, active-low): state IDLE; BUSY=0, DONE=0, R=0, O=N=Z=C=0; internal operand, counter and accumulator registers cleared.
- Reset mid-operation: the operation is abandoned and no DONE is produced.
- FSM states: IDLE, EXEC.
  - IDLE→EXEC on an edge t0 with START=1. A, B and CTRL are captured at t0 and BUSY=1 from t0.
  - EXEC→IDLE on the result edge tr. R and flags are registered at tr; BUSY=0 and DONE=1 for exactly the cycle after tr.
- START while BUSY=1 is ignored; inputs are not re-sampled.
- START in the DONE cycle is accepted (BUSY already 0), giving back-to-back operations.
- Opcodes and latency (tr - t0):
  - 000 ADD: A+B; 1 cycle
  - 001 SUB: A-B; 1 cycle
  - 010 AND; 1 cycle
  - 011 OR; 1 cycle
  - 100 XOR; 1 cycle
  - 101 SLT: R=1 if A<B signed, else 0; 1 cycle
  - 110 MUL: signed A*B, low WIDTH bits. Iterative, one partial product per cycle (radix-2 Booth or shift-add with sign correction); WIDTH cycles.
  - 111 SRA: A shifted right arithmetically by s=B[SHW-1:0], one bit per cycle; max(1,s) cycles. s=0 gives R=A.
- Flags, computed on the final R:
  - Z = (R==0); N = R[WIDTH-1].
  - O: ADD/SUB signed overflow; MUL when the full 2·WIDTH-bit product is not representable in WIDTH signed bits; 0 for all other ops.
  - C: ADD carry-out of the unsigned sum; SUB borrow (A<B unsigned); SRA last bit shifted out (0 when s=0); 0 for all other ops.
- Arithmetic is two's complement. Wrap-around on overflow, unless the optional feature below is enabled.
- Outputs R, O, N, Z and C change only at a result edge or at reset.

Optional Feature:
ALU_SAT_EN
- Defined: ADD, SUB and MUL saturate on overflow. R clamps to 2^(WIDTH-1)-1 if the true result is positive, or -2^(WIDTH-1) if negative. O is still set. N and Z reflect the clamped R. C is unchanged.
- Undefined: results wrap modulo 2^WIDTH and no saturation logic is synthesised.

Test Plan:
- Use WIDTH=4 throughout.
- ADD 0111+0001 → at t0+1: R=1000, O=1, N=1, Z=0, C=0, DONE pulse 1 cycle. With ALU_SAT_EN: R=0111, O=1, N=0.
- SUB 1010-1010 → R=0000, Z=1, O=0, C=0. SLT A=1110, B=0001 → R=0001. SUB 0001-0010 → R=1111, C=1, N=1.
- MUL 0011*1110 → DONE after t0+4, R=1010, N=1, O=0. MUL 0100*0100 → R=0000, O=1, Z=1; with ALU_SAT_EN → R=0111.
- SRA A=1000, B=0010 → result at t0+2: R=1110, C=0. SRA A=0111, B=0001 → R=0011, C=1. SRA with B=0000 → R=A at t0+1, C=0.
- Handshake:
  - Issue MUL, then pulse START with ADD at t0+1 → ignored; R is the MUL result only.
  - START ADD held through the DONE cycle → second result one cycle later; BUSY never low for more than one cycle.
- Reset mid-operation: assert RST=0 asynchronously mid-clock during a MUL at t0+2 → BUSY, DONE, R and flags go to 0 immediately. After RST=1, no DONE appears and a new ADD completes normally.
